// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates execute redirects, traps and stall sources, and
// produces PC jump/pause plus IF/ID and ID/EX flush controls.
module pipe_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_jump_addr,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            load_use,
    input  logic            div_busy,
    input  logic            bus_busy,
    output logic            jump,
    output logic [XLEN-1:0] jump_addr,
    output logic            pause,
    output logic            flush_if,
    output logic            flush_id,
    output logic            trap_ack,
    output logic [1:0]      state,
    output logic [31:0]     stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        TFLUSH = 2'd2,
        TJUMP  = 2'd3
    } state_t;

    state_t          cur, nxt;
    logic [XLEN-1:0] pend_addr;
    logic [XLEN-1:0] trap_addr;
    logic            latch_pend;
    logic            latch_trap;

    // State register plus the redirect targets captured on the way into HOLD/TFLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= RUN;
            pend_addr    <= '0;
            trap_addr    <= '0;
            stall_cycles <= '0;
        end else begin
            cur <= nxt;
            if (latch_pend) pend_addr <= ex_jump_addr;
            if (latch_trap) trap_addr <= trap_vec;
            if (pause)      stall_cycles <= stall_cycles + 32'd1;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            RUN: begin
                if (trap_req)                 nxt = TFLUSH;
                else if (ex_jump && bus_busy) nxt = HOLD;
            end
            HOLD:   if (!bus_busy) nxt = RUN;
            TFLUSH: nxt = TJUMP;
            TJUMP:  nxt = RUN;
            default: nxt = RUN;
        endcase
    end

    always_comb begin
        jump       = 1'b0;
        jump_addr  = '0;
        pause      = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        trap_ack   = 1'b0;
        latch_pend = 1'b0;
        latch_trap = 1'b0;
        unique case (cur)
            RUN: begin
                // Trap wins; a same-cycle execute redirect is dropped.
                if (trap_req) begin
                    latch_trap = 1'b1;
                end else if (ex_jump && !bus_busy) begin
                    jump      = 1'b1;
                    jump_addr = ex_jump_addr;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                end else if (ex_jump) begin
                    latch_pend = 1'b1;
                    pause      = 1'b1;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                end else begin
                    pause    = load_use | div_busy | bus_busy;
                    flush_id = load_use;
                end
            end
            HOLD: begin
                if (bus_busy) begin
                    pause    = 1'b1;
                    flush_if = 1'b1;
                end else begin
                    jump      = 1'b1;
                    jump_addr = pend_addr;
                end
            end
            TFLUSH: begin
                pause    = 1'b1;
                flush_if = 1'b1;
                flush_id = 1'b1;
            end
            TJUMP: begin
                jump      = 1'b1;
                jump_addr = trap_addr;
                trap_ack  = 1'b1;
            end
            default: ;
        endcase
        // The PC gives jump priority, so never ask it to pause at the same time.
        if (jump) pause = 1'b0;
    end

    assign state = cur;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a sequential vector table plus hand-written
// reset-abandon sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump;
    logic [31:0] ex_jump_addr;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        load_use;
    logic        div_busy;
    logic        bus_busy;
    logic        jump;
    logic [31:0] jump_addr;
    logic        pause;
    logic        flush_if;
    logic        flush_id;
    logic        trap_ack;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
        .trap_req(trap_req), .trap_vec(trap_vec),
        .load_use(load_use), .div_busy(div_busy), .bus_busy(bus_busy),
        .jump(jump), .jump_addr(jump_addr), .pause(pause),
        .flush_if(flush_if), .flush_id(flush_id), .trap_ack(trap_ack),
        .state(state), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic        ej;
        logic [31:0] ea;
        logic        tr;
        logic [31:0] tv;
        logic        lu;
        logic        db;
        logic        bb;
        logic        j;
        logic [31:0] ja;
        logic        p;
        logic        fi;
        logic        fd;
        logic        ta;
        logic [1:0]  st;
        logic [31:0] sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic ej, logic [31:0] ea, logic tr, logic [31:0] tv,
                               logic lu, logic db, logic bb,
                               logic j, logic [31:0] ja, logic p, logic fi, logic fd,
                               logic ta, logic [1:0] st, logic [31:0] sc);
        vec_t r;
        r.ej = ej; r.ea = ea; r.tr = tr; r.tv = tv; r.lu = lu; r.db = db; r.bb = bb;
        r.j = j; r.ja = ja; r.p = p; r.fi = fi; r.fd = fd; r.ta = ta; r.st = st; r.sc = sc;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        ex_jump = x.ej; ex_jump_addr = x.ea; trap_req = x.tr; trap_vec = x.tv;
        load_use = x.lu; div_busy = x.db; bus_busy = x.bb;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check(input vec_t e, input string tag);
        cmp({tag, ".jump"},      32'(jump),      32'(e.j));
        cmp({tag, ".jump_addr"}, jump_addr,      e.ja);
        cmp({tag, ".pause"},     32'(pause),     32'(e.p));
        cmp({tag, ".flush_if"},  32'(flush_if),  32'(e.fi));
        cmp({tag, ".flush_id"},  32'(flush_id),  32'(e.fd));
        cmp({tag, ".trap_ack"},  32'(trap_ack),  32'(e.ta));
        cmp({tag, ".state"},     32'(state),     32'(e.st));
        cmp({tag, ".stall"},     stall_cycles,   e.sc);
    endtask

    vec_t idle0;

    initial begin
        //            ej ea            tr tv            lu db bb   j ja            p fi fd ta st sc
        idle0 = v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 0);
        vecs.push_back(idle0);                                                                             // reset state
        vecs.push_back(v(1, 32'h80000100, 0, 32'h0, 0, 0, 0,  1, 32'h80000100, 0, 1, 1, 0, 0, 0));        // direct jump
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 32'h200, 0, 32'h0, 0, 0, 1,  0, 32'h0, 1, 1, 1, 0, 0, 0));                    // jump while bus busy
        vecs.push_back(v(1, 32'h999, 0, 32'h0, 0, 0, 1,  0, 32'h0, 1, 1, 0, 0, 1, 1));                    // HOLD, ex_jump ignored
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 1,  0, 32'h0, 1, 1, 0, 0, 1, 2));
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  1, 32'h200, 0, 0, 0, 0, 1, 3));                    // pending jump issued
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(1, 32'hDEAD0000, 1, 32'h80000004, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 3));        // trap beats jump
        vecs.push_back(v(0, 32'h0, 1, 32'h0, 0, 0, 0,  0, 32'h0, 1, 1, 1, 0, 2, 3));                      // TFLUSH
        vecs.push_back(v(0, 32'h0, 1, 32'h0, 0, 0, 0,  1, 32'h80000004, 0, 0, 0, 1, 3, 4));               // TJUMP
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 1, 0, 0,  0, 32'h0, 1, 0, 1, 0, 0, 4));                      // load-use
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 5));
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 1, 0,  0, 32'h0, 1, 0, 0, 0, 0, 5));                      // divider busy
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 1,  0, 32'h0, 1, 0, 0, 0, 0, 6));                      // fetch busy
        vecs.push_back(v(1, 32'h40, 0, 32'h0, 1, 0, 0,  1, 32'h40, 0, 1, 1, 0, 0, 7));                    // jump over load-use
        vecs.push_back(v(1, 32'h300, 0, 32'h0, 0, 0, 1,  0, 32'h0, 1, 1, 1, 0, 0, 7));
        vecs.push_back(v(0, 32'h0, 1, 32'h100, 0, 0, 1,  0, 32'h0, 1, 1, 0, 0, 1, 8));                    // trap ignored in HOLD
        vecs.push_back(v(0, 32'h0, 1, 32'h100, 0, 0, 0,  1, 32'h300, 0, 0, 0, 0, 1, 9));
        vecs.push_back(v(0, 32'h0, 1, 32'h100, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 9));                    // trap taken from RUN
        vecs.push_back(v(0, 32'h0, 1, 32'h0, 0, 0, 0,  0, 32'h0, 1, 1, 1, 0, 2, 9));
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  1, 32'h100, 0, 0, 0, 1, 3, 10));
        vecs.push_back(v(0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 0, 0, 0, 10));

        rst = 1'b1;
        drive(idle0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Reset mid-HOLD: redirect to 0x500 must be abandoned.
        drive(v(1, 32'h500, 0, 32'h0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(v(0, 32'h0, 0, 32'h0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check(v(0, 0, 0, 0, 0, 0, 0,  0, 32'h0, 1, 1, 0, 0, 1, 11), "hold_pre");
        rst = 1'b1;
        drive(idle0);
        #1;
        check(idle0, "hold_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check(idle0, $sformatf("hold_post%0d", k));
            @(posedge clk); #1;
        end

        // Reset mid-TFLUSH: no TJUMP / trap_ack afterwards.
        drive(v(0, 32'h0, 1, 32'h80000040, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        #1;
        check(v(0, 0, 0, 0, 0, 0, 0,  0, 32'h0, 1, 1, 1, 0, 2, 0), "tf_pre");
        rst = 1'b1;
        drive(idle0);
        #1;
        check(idle0, "tf_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check(idle0, $sformatf("tf_post%0d", k));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: XLEN, 32, datapath and address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_jump  input  1  execute stage requests a redirect (branch taken, jal/jalr, mret).
REQ-005 ex_jump_addr  input  XLEN  execute redirect target.
REQ-006 trap_req  input  1  trap/interrupt pending; the source holds it high until trap_ack.
REQ-007 trap_vec  input  XLEN  trap handler address.
REQ-008 load_use  input  1  decode detected a load-use hazard.
REQ-009 div_busy  input  1  multi-cycle divider is occupied.
REQ-010 bus_busy  input  1  instruction fetch is in flight on the bus.
REQ-011 jump  output  1  drives the program counter's jump input.
REQ-012 jump_addr  output  XLEN  drives the program counter's jump address input.
REQ-013 pause  output  1  drives the program counter's pause input and the IF/ID hold.
REQ-014 flush_if  output  1  invalidates the IF/ID register.
REQ-015 flush_id  output  1  inserts a bubble into the ID/EX register.
REQ-016 trap_ack  output  1  one-cycle acknowledge of a taken trap.
REQ-017 state  output  2  current FSM state (RUN=0, HOLD=1, TFLUSH=2, TJUMP=3).
REQ-018 stall_cycles  output  32  count of cycles with pause=1.

Function
REQ-019 The FSM SHALL be registered; all other outputs SHALL be combinational from the state, the latched registers and the current inputs.
REQ-020 Outputs not explicitly driven in a state SHALL be 0; jump_addr SHALL be 0 whenever jump=0.
REQ-021 In RUN, if trap_req=1, the block SHALL latch trap_vec into trap_addr and go to TFLUSH; any ex_jump in that cycle SHALL be discarded because trap has priority.
REQ-022 In RUN with trap_req=0, ex_jump=1 and bus_busy=0, the block SHALL assert jump=1, jump_addr=ex_jump_addr, flush_if=1 and flush_id=1 in the same cycle, and stay in RUN.
REQ-023 In RUN with trap_req=0, ex_jump=1 and bus_busy=1, the block SHALL latch ex_jump_addr into pend_addr, assert pause=1, flush_if=1 and flush_id=1, and go to HOLD.
REQ-024 In RUN with no jump and no trap, the block SHALL assert pause=load_use|div_busy|bus_busy and flush_id=load_use.
REQ-025 In HOLD, the block SHALL assert pause=1 and flush_if=1 while bus_busy=1.
REQ-026 In HOLD, once bus_busy=0, the block SHALL assert jump=1 with jump_addr=pend_addr, pause=0, and return to RUN.
REQ-027 In HOLD, trap_req and ex_jump SHALL be ignored; a trap is taken from RUN on a later cycle.
REQ-028 TFLUSH SHALL last exactly one cycle with pause=1, flush_if=1 and flush_id=1, then go to TJUMP unconditionally.
REQ-029 TJUMP SHALL last exactly one cycle with jump=1, jump_addr=trap_addr and trap_ack=1, then return to RUN.
REQ-030 Whenever jump=1, the block SHALL force pause=0, since the program counter gives jump priority.
REQ-031 stall_cycles SHALL increment by 1 on each clock edge where pause=1 and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 On rst=1, asynchronously: state=RUN, pend_addr=0, trap_addr=0, stall_cycles=0; all combinational outputs then follow the RUN rules.
REQ-033 Reset asserted mid-HOLD or mid-TFLUSH/TJUMP SHALL abandon the pending redirect; no jump or trap_ack is issued after release.

Verification
REQ-034 Release reset with idle inputs -> state=0, jump=0, pause=0, stall_cycles=0.
REQ-035 ex_jump=1, addr=0x80000100, bus_busy=0 -> the same cycle shows jump=1, jump_addr=0x80000100, flush_if=flush_id=1, state stays 0.
REQ-036 ex_jump=1, addr=0x200, bus_busy=1 for 3 cycles -> HOLD with pause=1; the cycle bus_busy falls shows jump=1, jump_addr=0x200; stall_cycles=3.
REQ-037 trap_req=1 and ex_jump=1 together, trap_vec=0x80000004 -> next cycle TFLUSH (pause, flushes), then TJUMP (jump_addr=0x80000004, trap_ack=1), then RUN; no jump to the ex address.
REQ-038 load_use=1 for 1 cycle -> pause=1, flush_id=1, flush_if=0, stall_cycles increments by 1.
REQ-039 rst pulsed while in HOLD -> state=0 immediately; no jump is issued after release.
